// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: the bus signals of mem_access_unit, grouped in one bundle.
//   CPU side : BusMuxOut, MARin, MDRin, Read, Write (into the unit)
//              MDRdata, Busy, Done, Err (out of the unit)
//   RAM side : mem_addr, mem_wdata, mem_re, mem_we (out of the unit)
//              mem_rdata (into the unit)
// The master modport is the environment (control unit plus RAM).
// The slave modport is the access unit itself.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [31:0]       BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              Read;
  logic              Write;
  logic [31:0]       MDRdata;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport master (
    output BusMuxOut, MARin, MDRin, Read, Write, mem_rdata,
    input  MDRdata, Busy, Done, Err, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport slave (
    input  BusMuxOut, MARin, MDRin, Read, Write, mem_rdata,
    output MDRdata, Busy, Done, Err, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR pair plus a fixed-latency RAM access sequencer.
//   Clock : rising-edge clock
//   Reset : asynchronous, active-low
//   bus   : mem_access_unit_if slave. It carries:
//           - the CPU bus value and the MARin, MDRin, Read and Write controls;
//           - the MDR output, and the Busy, Done and Err status;
//           - the RAM strobes, address, write data and read data.
// A read starts on Read&MDRin in IDLE. A write starts on Write&!Read in IDLE.
// Each access keeps Busy high for LATENCY cycles. Done then pulses for one cycle.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2
) (
  input logic          Clock,
  input logic          Reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic idle, start_rd, start_wr, last;

  assign idle     = (state_q == IDLE);
  assign start_rd = idle && bus.Read && bus.MDRin;
  assign start_wr = idle && bus.Write && !bus.Read;
  // The counter steps 1 -> 0 on this edge, which ends the access.
  assign last     = !idle && (cnt_q == 4'd1);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_rd) begin
          state_d = RD;
          cnt_d   = LAT;
        end else if (start_wr) begin
          state_d = WR;
          cnt_d   = LAT;
        end
      end
      RD, WR: begin
        cnt_d = cnt_q - 4'd1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. mem_we is asserted only in the first WR cycle, while the counter is still full.
  always_comb begin
    bus.Busy      = !idle;
    bus.mem_re    = (state_q == RD);
    bus.mem_we    = (state_q == WR) && (cnt_q == LAT);
    bus.Done      = done_q;
    bus.Err       = err_q;
    bus.MDRdata   = mdr_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
  end

  // Datapath next-state logic
  always_comb begin
    mar_d   = bus.MARin ? bus.BusMuxOut[ADDR_W-1:0] : mar_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdr_d   = mdr_q;
    done_d  = last;
    // Any request seen while busy is dropped. A simultaneous Read+Write in IDLE is also flagged.
    err_d   = err_q
            | (!idle && (bus.Read || bus.Write))
            | (idle && bus.Read && bus.Write);
    if (start_rd) begin
      addr_d = mar_q;
    end else if (start_wr) begin
      addr_d  = mar_q;
      wdata_d = bus.BusMuxOut;
      mdr_d   = bus.BusMuxOut;
    end else if (idle && bus.MDRin && !bus.Read) begin
      mdr_d = bus.BusMuxOut;
    end
    if (last && (state_q == RD)) mdr_d = bus.mem_rdata;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mar_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mar_q   <= mar_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
// Three instances, with LATENCY=1, 2 and 15, share the same stimulus.
// Per-instance counters record Busy, mem_re, mem_we and Done cycles, sampled on the falling edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_v;
  logic        marin, mdrin, rd, wr;

  int checks   = 0;
  int failures = 0;

  logic        busy_w [3];
  logic        done_w [3];
  logic        err_w  [3];
  logic        re_w   [3];
  logic        we_w   [3];
  logic [31:0] mdr_w  [3];
  logic [31:0] wdat_w [3];
  logic [8:0]  addr_w [3];

  int          busy_n [3] = '{0, 0, 0};
  int          re_n   [3] = '{0, 0, 0};
  int          we_n   [3] = '{0, 0, 0};
  int          done_n [3] = '{0, 0, 0};
  int          bad_n  [3] = '{0, 0, 0};
  logic [8:0]  we_addr[3] = '{9'h0, 9'h0, 9'h0};
  logic [31:0] we_data[3] = '{32'h0, 32'h0, 32'h0};
  logic [8:0]  exp_addr = 9'h055;

  int s_busy[3], s_re[3], s_we[3], s_done[3], s_bad[3];

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [8:0] a);
    return (a == 9'h055) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(a));
  endfunction

  function automatic int lat(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 15);
  endfunction

  function automatic string tg(input int g, input string s);
    return $sformatf("L%0d_%s", lat(g), s);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_unit_if #(.ADDR_W(9)) ifc ();
    assign ifc.BusMuxOut = bus_v;
    assign ifc.MARin     = marin;
    assign ifc.MDRin     = mdrin;
    assign ifc.Read      = rd;
    assign ifc.Write     = wr;
    assign ifc.mem_rdata = ram_word(ifc.mem_addr);

    mem_access_unit #(
      .ADDR_W (9),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 15))
    ) dut (
      .Clock(clk),
      .Reset(rst_n),
      .bus  (ifc)
    );

    assign busy_w[g] = ifc.Busy;
    assign done_w[g] = ifc.Done;
    assign err_w[g]  = ifc.Err;
    assign re_w[g]   = ifc.mem_re;
    assign we_w[g]   = ifc.mem_we;
    assign mdr_w[g]  = ifc.MDRdata;
    assign wdat_w[g] = ifc.mem_wdata;
    assign addr_w[g] = ifc.mem_addr;
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (busy_w[g]) busy_n[g]++;
      if (re_w[g])   re_n[g]++;
      if (done_w[g]) done_n[g]++;
      if (we_w[g]) begin
        we_n[g]++;
        we_addr[g] = addr_w[g];
        we_data[g] = wdat_w[g];
      end
      if (re_w[g] && (addr_w[g] != exp_addr)) bad_n[g]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic snap();
    for (int g = 0; g < 3; g++) begin
      s_busy[g] = busy_n[g];
      s_re[g]   = re_n[g];
      s_we[g]   = we_n[g];
      s_done[g] = done_n[g];
      s_bad[g]  = bad_n[g];
    end
  endtask

  task automatic load_mar(input logic [31:0] v);
    bus_v = v;
    marin = 1'b1;
    tick(1);
    marin = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus_v = '0;
    marin = 1'b0;
    mdrin = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "rst_busy"), busy_w[g], 1'b0);
      check(tg(g, "rst_err"),  err_w[g],  1'b0);
      check(tg(g, "rst_mdr"),  mdr_w[g],  32'h0);
      check(tg(g, "rst_re"),   re_w[g],   1'b0);
      check(tg(g, "rst_addr"), addr_w[g], 9'h0);
    end
    rst_n = 1'b1;
    tick(1);

    // Read from 0x55
    load_mar(32'h0000_0055);
    exp_addr = 9'h055;
    snap();
    rd = 1'b1; mdrin = 1'b1;
    tick(1);
    rd = 1'b0; mdrin = 1'b0;
    tick(18);
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "rd_busy"), busy_n[g] - s_busy[g], lat(g));
      check(tg(g, "rd_re"),   re_n[g]   - s_re[g],   lat(g));
      check(tg(g, "rd_done"), done_n[g] - s_done[g], 1);
      check(tg(g, "rd_mdr"),  mdr_w[g], 32'hDEAD_BEEF);
      check(tg(g, "rd_err"),  err_w[g], 1'b0);
    end

    // Write 0x12345678 to 0x1F0
    load_mar(32'h0000_01F0);
    snap();
    bus_v = 32'h1234_5678; wr = 1'b1;
    tick(1);
    wr = 1'b0; bus_v = '0;
    tick(18);
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "wr_we"),    we_n[g]   - s_we[g],   1);
      check(tg(g, "wr_busy"),  busy_n[g] - s_busy[g], lat(g));
      check(tg(g, "wr_done"),  done_n[g] - s_done[g], 1);
      check(tg(g, "wr_addr"),  we_addr[g], 9'h1F0);
      check(tg(g, "wr_wdata"), we_data[g], 32'h1234_5678);
      check(tg(g, "wr_mdr"),   mdr_w[g],   32'h1234_5678);
    end

    // Collision: a Write and a MAR reload arrive one cycle into the read
    load_mar(32'h0000_0055);
    snap();
    rd = 1'b1; mdrin = 1'b1;
    tick(1);
    rd = 1'b0; mdrin = 1'b0;
    bus_v = '0; marin = 1'b1; wr = 1'b1;
    tick(1);
    marin = 1'b0; wr = 1'b0;
    tick(18);
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "col_we"),   we_n[g]   - s_we[g],   0);
      check(tg(g, "col_busy"), busy_n[g] - s_busy[g], lat(g));
      check(tg(g, "col_done"), done_n[g] - s_done[g], 1);
      check(tg(g, "col_mdr"),  mdr_w[g], 32'hDEAD_BEEF);
      check(tg(g, "col_err"),  err_w[g], 1'b1);
      check(tg(g, "col_addr"), bad_n[g] - s_bad[g], 0);
    end

    // Reset one cycle into a read
    load_mar(32'h0000_0055);
    snap();
    rd = 1'b1; mdrin = 1'b1;
    tick(1);
    rd = 1'b0; mdrin = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "rr_busy"), busy_w[g], 1'b0);
      check(tg(g, "rr_re"),   re_w[g],   1'b0);
      check(tg(g, "rr_mdr"),  mdr_w[g],  32'h0);
      check(tg(g, "rr_err"),  err_w[g],  1'b0);
    end
    tick(1);
    rst_n = 1'b1;
    tick(18);
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "rr_done"), done_n[g] - s_done[g], 0);
      check(tg(g, "rr_mdr2"), mdr_w[g], 32'h0);
    end

    // Read without MDRin starts nothing and raises no error
    load_mar(32'h0000_0055);
    snap();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    tick(18);
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "nomdr_busy"), busy_n[g] - s_busy[g], 0);
      check(tg(g, "nomdr_err"),  err_w[g], 1'b0);
    end

    // Back-to-back: the request is held for three edges
    snap();
    rd = 1'b1; mdrin = 1'b1;
    tick(3);
    rd = 1'b0; mdrin = 1'b0;
    tick(20);
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "b2b_done"), done_n[g] - s_done[g], (g == 0) ? 2 : 1);
      check(tg(g, "b2b_busy"), busy_n[g] - s_busy[g], (g == 0) ? 2 : lat(g));
      check(tg(g, "b2b_err"),  err_w[g], 1'b1);
      check(tg(g, "b2b_mdr"),  mdr_w[g], 32'hDEAD_BEEF);
    end

    // Read and Write together: only the read runs, and Err is set
    do_reset();
    load_mar(32'h0000_0055);
    snap();
    bus_v = 32'h0BAD_F00D; rd = 1'b1; wr = 1'b1; mdrin = 1'b1;
    tick(1);
    rd = 1'b0; wr = 1'b0; mdrin = 1'b0; bus_v = '0;
    tick(18);
    for (int g = 0; g < 3; g++) begin
      check(tg(g, "rw_re"),   re_n[g]   - s_re[g],   lat(g));
      check(tg(g, "rw_we"),   we_n[g]   - s_we[g],   0);
      check(tg(g, "rw_done"), done_n[g] - s_done[g], 1);
      check(tg(g, "rw_err"),  err_w[g], 1'b1);
      check(tg(g, "rw_mdr"),  mdr_w[g], 32'hDEAD_BEEF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
